// File: rtl/sprite_pkg.sv
// Shared payload types and colour constants for the sprite compositor.
package sprite_pkg;

    localparam int unsigned SPR_COORD_W = 10;
    localparam int unsigned SPR_COLOR_W = 8;

    typedef struct packed {
        logic [SPR_COLOR_W-1:0] r;
        logic [SPR_COLOR_W-1:0] g;
        logic [SPR_COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        logic [SPR_COORD_W-1:0] size;
        rgb_t                   rgb;
        logic                   en;
        logic                   flash;
    } sprite_attr_t;

    localparam rgb_t MAP_RGB  = rgb_t'(24'h47B7AE);
    localparam rgb_t TEXT_RGB = rgb_t'(24'hFFFFFF);
    localparam rgb_t BLACK    = rgb_t'(24'h000000);

endpackage

// File: rtl/sprite_hit_pipe.sv
// Per-sprite circle test: stage 1 registers signed offsets, stage 2 registers
// the hit bit and the colour (flash substitution already applied).
module sprite_hit_pipe
    import sprite_pkg::*;
#(
    parameter rgb_t FLASH_RGB = rgb_t'(24'hFFFFFF)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [SPR_COORD_W-1:0] draw_x,
    input  logic [SPR_COORD_W-1:0] draw_y,
    input  sprite_attr_t           attr,
    input  logic                   flash_phase,
    output logic                   hit,
    output rgb_t                   rgb
);

    localparam int unsigned D_W    = SPR_COORD_W + 1;
    localparam int unsigned SQ_W   = 2 * SPR_COORD_W + 2;
    localparam int unsigned DIST_W = 2 * SPR_COORD_W + 1;

    logic signed [D_W-1:0]  dx_q;
    logic signed [D_W-1:0]  dy_q;
    logic [SPR_COORD_W-1:0] size_q;
    logic                   live_q;
    rgb_t                   rgb1_q;

    logic signed [SQ_W-1:0] dx_sq_c;
    logic signed [SQ_W-1:0] dy_sq_c;
    logic [DIST_W-1:0]      dist2_c;
    logic [DIST_W-1:0]      size2_c;

    // Stage 1: offsets are signed so sprites hanging off the left/top edge still work.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dx_q   <= '0;
            dy_q   <= '0;
            size_q <= '0;
            live_q <= 1'b0;
            rgb1_q <= '0;
        end else begin
            dx_q   <= $signed({1'b0, draw_x}) - $signed({1'b0, attr.x});
            dy_q   <= $signed({1'b0, draw_y}) - $signed({1'b0, attr.y});
            size_q <= attr.size;
            live_q <= attr.en && (attr.size != '0);
            rgb1_q <= (attr.flash && flash_phase) ? FLASH_RGB : attr.rgb;
        end
    end

    always_comb begin
        dx_sq_c = SQ_W'(dx_q) * SQ_W'(dx_q);
        dy_sq_c = SQ_W'(dy_q) * SQ_W'(dy_q);
        dist2_c = DIST_W'(dx_sq_c) + DIST_W'(dy_sq_c);
        size2_c = DIST_W'(size_q) * DIST_W'(size_q);
    end

    // Stage 2: the circle edge (dist2 == size2) is inside.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit <= 1'b0;
            rgb <= '0;
        end else begin
            hit <= live_q && (dist2_c <= size2_c);
            rgb <= rgb1_q;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined pixel compositor: circular sprites over text, maze and background,
// fixed 3-cycle latency, sprite attributes shadowed at frame start.
module sprite_compositor
    import sprite_pkg::rgb_t;
    import sprite_pkg::sprite_attr_t;
#(
    parameter int unsigned         NUM_SPRITES = 5,
    parameter int unsigned         COORD_W     = sprite_pkg::SPR_COORD_W,
    parameter int unsigned         COLOR_W     = sprite_pkg::SPR_COLOR_W,
    parameter int unsigned         PLAYFIELD_W = 405,
    parameter int unsigned         FLASH_LOG2  = 4,
    parameter logic [3*COLOR_W-1:0] TEXT_RGB   = sprite_pkg::TEXT_RGB,
    parameter logic [3*COLOR_W-1:0] MAP_RGB    = sprite_pkg::MAP_RGB,
    parameter logic [3*COLOR_W-1:0] FLASH_RGB  = 24'hFFFFFF
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               frame_start,
    input  logic                               pix_valid,
    input  logic [COORD_W-1:0]                 DrawX,
    input  logic [COORD_W-1:0]                 DrawY,
    input  logic                               blank,
    input  logic                               text_on,
    input  logic                               map_on,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_y,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_size,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0]   spr_rgb,
    input  logic [NUM_SPRITES-1:0]             spr_en,
    input  logic [NUM_SPRITES-1:0]             spr_flash,
    output logic                               rgb_valid,
    output logic [COLOR_W-1:0]                 Red,
    output logic [COLOR_W-1:0]                 Green,
    output logic [COLOR_W-1:0]                 Blue,
    output logic [$clog2(NUM_SPRITES+1)-1:0]   hit_id
);

    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned ID_W  = $clog2(NUM_SPRITES + 1);

    sprite_attr_t            attr_in_c [NUM_SPRITES];
    sprite_attr_t            shadow_q  [NUM_SPRITES];
    logic [FLASH_LOG2-1:0]   frame_cnt_q;

    logic                    valid1_q, vis1_q, text1_q, map1_q;
    logic                    valid2_q, vis2_q, text2_q, map2_q;

    logic [NUM_SPRITES-1:0]  hit_s2;
    rgb_t                    spr_rgb_s2 [NUM_SPRITES];

    logic                    win_any_c;
    logic [ID_W-1:0]         win_id_c;
    rgb_t                    win_rgb_c;
    rgb_t                    pix_rgb_c;
    logic [ID_W-1:0]         pix_id_c;

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            attr_in_c[i].x     = spr_x[i*COORD_W +: COORD_W];
            attr_in_c[i].y     = spr_y[i*COORD_W +: COORD_W];
            attr_in_c[i].size  = spr_size[i*COORD_W +: COORD_W];
            attr_in_c[i].rgb   = rgb_t'(spr_rgb[i*RGB_W +: RGB_W]);
            attr_in_c[i].en    = spr_en[i];
            attr_in_c[i].flash = spr_flash[i];
        end
    end

    // Shadow attributes only move at frame start, so a frame never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= attr_in_c[i];
            frame_cnt_q <= frame_cnt_q + FLASH_LOG2'(1);
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_hit_pipe #(
            .FLASH_RGB (rgb_t'(FLASH_RGB))
        ) u_hit_pipe (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .draw_x      (DrawX),
            .draw_y      (DrawY),
            .attr        (shadow_q[i]),
            .flash_phase (frame_cnt_q[FLASH_LOG2-1]),
            .hit         (hit_s2[i]),
            .rgb         (spr_rgb_s2[i])
        );
    end

    // Pixel side-band carried alongside the per-sprite distance pipes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid1_q <= 1'b0;
            vis1_q   <= 1'b0;
            text1_q  <= 1'b0;
            map1_q   <= 1'b0;
            valid2_q <= 1'b0;
            vis2_q   <= 1'b0;
            text2_q  <= 1'b0;
            map2_q   <= 1'b0;
        end else begin
            valid1_q <= pix_valid;
            vis1_q   <= blank && (DrawX < COORD_W'(PLAYFIELD_W));
            text1_q  <= text_on;
            map1_q   <= map_on;
            valid2_q <= valid1_q;
            vis2_q   <= vis1_q;
            text2_q  <= text1_q;
            map2_q   <= map1_q;
        end
    end

    // Lowest-index hit wins; then text, then maze, then black.
    always_comb begin
        win_any_c = 1'b0;
        win_id_c  = ID_W'(NUM_SPRITES);
        win_rgb_c = sprite_pkg::BLACK;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s2[i]) begin
                win_any_c = 1'b1;
                win_id_c  = ID_W'(i);
                win_rgb_c = spr_rgb_s2[i];
            end
        end
        pix_rgb_c = sprite_pkg::BLACK;
        pix_id_c  = ID_W'(NUM_SPRITES);
        if (vis2_q) begin
            if (win_any_c) begin
                pix_rgb_c = win_rgb_c;
                pix_id_c  = win_id_c;
            end else if (text2_q) begin
                pix_rgb_c = rgb_t'(TEXT_RGB);
            end else if (map2_q) begin
                pix_rgb_c = rgb_t'(MAP_RGB);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_valid <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            hit_id    <= '0;
        end else begin
            rgb_valid <= valid2_q;
            Red       <= pix_rgb_c.r;
            Green     <= pix_rgb_c.g;
            Blue      <= pix_rgb_c.b;
            hit_id    <= pix_id_c;
        end
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined pixel compositor for the game display, driven by the VGA scan (DrawX/DrawY).
- Composites NUM_SPRITES circular sprites (Pac-Man plus ghosts), a text layer, the maze mask and a background colour into registered RGB.
- Sprite attributes are double-buffered at frame start so mid-frame updates never tear.
- Has per-sprite flashing driven by an internal frame counter, e.g. for frightened ghosts.

Parameters:
- NUM_SPRITES, 5, number of sprite layers; index 0 has highest priority.
- COORD_W, 10, width of DrawX, DrawY, sprite X/Y and size.
- COLOR_W, 8, bits per colour channel.
- PLAYFIELD_W, 405, pixels with DrawX >= PLAYFIELD_W are forced black.
- FLASH_LOG2, 4, flash half-period is 2^(FLASH_LOG2-1) frames.
- TEXT_RGB, 24'hFFFFFF, text colour.
- MAP_RGB, 24'h47B7AE, maze colour.
- FLASH_RGB, 24'hFFFFFF, colour substituted for flashing sprites in the flash-on phase.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  a new pixel is presented this cycle.
- DrawX, DrawY  in  COORD_W each  pixel coordinates.
- blank  in  1  0 = blanking interval.
- text_on  in  1  text layer hit for this pixel, aligned with pix_valid.
- map_on  in  1  maze mask hit for this pixel, aligned with pix_valid.
- spr_x, spr_y, spr_size  in  NUM_SPRITES*COORD_W each  packed centre coordinates and radius.
- spr_rgb  in  NUM_SPRITES*3*COLOR_W  packed colour, R in MSBs.
- spr_en, spr_flash  in  NUM_SPRITES each  enable and flash request.
- rgb_valid  out  1  Red/Green/Blue correspond to the pixel presented 3 cycles earlier.
- Red, Green, Blue  out  COLOR_W each  pixel colour.
- hit_id  out  $clog2(NUM_SPRITES+1)  index of the winning sprite; NUM_SPRITES if none.

Behaviour:
- Reset (asynchronous, Reset_n low): all pipeline registers, shadow attribute registers and the frame counter clear to 0.
  - Outputs are 0 during reset: rgb_valid=0, RGB=0, hit_id=0.
  - Shadow spr_en=0, so no sprite draws until the first frame_start.
- Shadow load: on a cycle with frame_start=1, shadow <= spr_* inputs and frame_cnt <= frame_cnt+1 (wraps modulo 2^FLASH_LOG2).
  - A pixel coinciding with frame_start uses the old shadow values.
- flash_phase = frame_cnt[FLASH_LOG2-1].
- Pipeline: fixed latency of 3 cycles and no stalls. pix_valid is carried alongside the pixel and appears as rgb_valid.
  - S1: register DrawX, DrawY, blank, text_on, map_on, valid. Compute dx = DrawX - spr_x and dy = DrawY - spr_y per sprite as signed COORD_W+1.
  - S2: register dx^2 + dy^2 (2*COORD_W+1 bits, unsigned) and size^2 per sprite.
  - S3: hit[i] = en[i] && size[i] != 0 && dist2[i] <= size2[i]. The lowest hit index wins. Colour select is registered into the outputs.
- Colour priority, highest first:
  - blank=0 → black.
  - DrawX >= PLAYFIELD_W → black.
  - winning sprite → its colour, or FLASH_RGB if spr_flash && flash_phase.
  - text_on → TEXT_RGB.
  - map_on → MAP_RGB.
  - otherwise black.
- hit_id reports the winning sprite only when the pixel is visible (blank=1 and DrawX < PLAYFIELD_W); otherwise it is NUM_SPRITES.
- Boundaries:
  - dist2 == size2 counts as a hit.
  - Sprites partly off-screen (spr_x < size) draw correctly via signed arithmetic.
  - size=0 never draws.
  - If pix_valid=0, outputs still update but rgb_valid=0.
  - Reset mid-frame clears the pipeline immediately. The first valid output appears 3 cycles after the first pix_valid following release.

Decomposition:
- Package sprite_pkg: rgb_t struct (r, g, b of COLOR_W), sprite_attr_t struct (x, y, size, rgb, en, flash), colour constants MAP_RGB, TEXT_RGB, BLACK.
- Sub-module: sprite_hit_pipe, one instance per sprite via generate. It performs S1 and S2 distance math and outputs a registered hit bit.

Test Plan:
- Reset, then frame_start with spr0 at (100,100), size 8, colour FFFF00, en. Scan row 100 → yellow for X 92..108, hit_id=0. X=91 → map or black. Output 3 cycles after input.
- Overlapping sprites 0 and 2 at the same centre, different colours → sprite 0 colour and hit_id=0. Disable sprite 0 → sprite 2 shown.
- Change spr_x mid-frame from 100 to 200 without frame_start → output still at 100. After the next frame_start → drawn at 200.
- spr_flash=1, FLASH_LOG2=4 → sprite colour for 8 frames, FLASH_RGB for 8 frames, repeating. Flash bit wraps correctly after frame_cnt=15.
- Layer priority: text_on=1 and map_on=1 under no sprite → FFFFFF. Only map_on → 47B7AE. blank=0 → 000000. DrawX=405 with sprite hit → 000000, hit_id=NUM_SPRITES.
- Assert Reset_n low mid-scan → outputs 0 immediately, not at the next clock edge. Sprites are not drawn again until the next frame_start.
